mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port request arbiter and sequencer in front of the single-port `main_memory` block. Shares the memory between port 0 (instruction fetch) and port 1 (load/store unit) with round-robin arbitration. Runs each access as a fixed issue/wait/complete sequence against the memory's `mem_read`/`mem_write`/`mem_ready` interface. Bounds every access with a timeout so a missing `mem_ready` cannot hang either requester.

## Interface
- `TIMEOUT`, 15: maximum WAIT cycles without `mem_ready` before the access is aborted with an error; must be ≥ 1.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0` / `req1` in 1: request from port 0 / port 1; held high with stable `we`/`addr`/`wdata` until that port's `done`.
- `we0` / `we1` in 1: 1 = write, 0 = read.
- `addr0` / `addr1` in `XLEN`: word address.
- `wdata0` / `wdata1` in `XLEN`: write data.
- `done0` / `done1` out 1: one-cycle completion pulse.
- `err0` / `err1` out 1: valid with `done`; 1 = access timed out.
- `rdata0` / `rdata1` out `XLEN`: read data, valid from the `done` cycle and held until that port's next completed read.
- `busy` out 1: high in every state except IDLE.
- `grant_id` out 1: port owning the current access; meaningful only while `busy` is high.
- `mem_addr` out `XLEN`: to memory `addr`.
- `mem_write_data` out `XLEN`: to memory `write_data`.
- `mem_read` / `mem_write` out 1: to memory; never both high.
- `mem_ready` in 1: from memory; one-cycle pulse the cycle after issue.
- `mem_read_data` in `XLEN`: from memory `read_data`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs are registered or decoded from state only, with no combinational input-to-output paths.
- **IDLE**
  - If no request is pending, stay in IDLE.
  - If exactly one request is pending, that port wins.
  - If both are pending, the port named by priority pointer `prio` wins.
  - On a grant:
    - latch the winner's `we`/`addr`/`wdata` into `mem_addr`/`mem_write_data` and an internal `we_q`;
    - set `grant_id` = winner;
    - set `prio` = other port;
    - go to ISSUE.
- **ISSUE** (exactly one cycle)
  - Drive `mem_read` = !`we_q`, `mem_write` = `we_q`.
  - Clear the timeout counter.
  - Go to WAIT.
- **WAIT**
  - `mem_read` and `mem_write` are low.
  - If `mem_ready` is high:
    - for a read, capture `mem_read_data` into `rdata[grant_id]`;
    - set err = 0;
    - go to DONE.
  - Otherwise increment the counter; when it reaches `TIMEOUT`, set err = 1, leave `rdata` unchanged, and go to DONE.
- **DONE** (exactly one cycle)
  - `done[grant_id]` = 1 and `err[grant_id]` = err; the other port's `done`/`err` stay 0.
  - Requests are ignored in this cycle.
  - Go to IDLE.
- Requesters update or drop `req` in the cycle after `done`. A `req` still high in IDLE is treated as a new request.
- A `mem_ready` arriving in IDLE, ISSUE or DONE is ignored.
- Writes never modify `rdata0`/`rdata1`.
- Counter width is `$clog2(TIMEOUT+1)`; it saturates and never wraps.
- **Reset** (`rst_n` low, asynchronous, including mid-access):
  - state = IDLE; `prio` = 0; counter = 0.
  - `done0`/`done1`/`err0`/`err1`/`mem_read`/`mem_write`/`busy`/`grant_id` = 0.
  - `mem_addr`/`mem_write_data`/`rdata0`/`rdata1` = 0.
  - An in-flight access is dropped with no `done`.

## Timing
- `req` sampled high in IDLE at cycle N gives:
  - ISSUE (`mem_read`/`mem_write` high) in N+1;
  - `mem_ready` and WAIT in N+2;
  - DONE (`done` pulse, `rdata` valid) in N+3;
  - IDLE in N+4.
- With a normal memory, request-to-done latency is 3 cycles and throughput is one access per 4 cycles.
- Timeout path: `done` with `err` = 1 arrives in cycle N+2+`TIMEOUT`.
- A port with `req` held continuously is never starved: with both ports requesting continuously, grants alternate 0,1,0,1…
- Reset deassertion takes effect at the next rising edge; the first grant is possible in the first cycle after reset.

## Test plan
- **Single read:** preload memory[5] = 0xDEADBEEF; `req0`=1, `we0`=0, `addr0`=5 → `mem_read` high exactly 1 cycle; `done0` 3 cycles after the request; `rdata0` = 0xDEADBEEF; `err0` = 0; `done1` stays 0.
- **Write then read on port 1:** write 0x12345678 to addr 9, then read addr 9 → the write's `done1` leaves `rdata1` unchanged; the read returns 0x12345678.
- **Contention:** both `req0` and `req1` held continuously with distinct addresses from reset → grants 0,1,0,1; one `done` every 4 cycles; each port's `rdata` matches its own address.
- **Timeout:** stub memory never asserts `mem_ready`, `TIMEOUT` = 4 → `done0`=1 and `err0`=1 in request cycle +6; `rdata0` unchanged; FSM back in IDLE.
- **Reset mid-access:** drop `rst_n` during WAIT → all outputs 0 immediately; no `done`; after release, a new `req1` is granted first-cycle and completes normally.
- **Late ready:** stub asserts `mem_ready` after 3 WAIT cycles, `TIMEOUT` = 15 → `done` with `err` = 0 and correct data; a stray `mem_ready` in IDLE causes no `done`.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles every signal between the two requesters, the arbiter and the
// single-port memory.
//   slave  : arbiter side (takes requests and mem_ready/mem_read_data,
//            drives completions and the memory command bus)
//   master : environment side (requesters plus memory)
// Signals:
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1 : requester commands
//   done0/done1, err0/err1, rdata0/rdata1          : per-port completions
//   busy, grant_id                                 : arbiter status
//   mem_addr, mem_write_data, mem_read, mem_write  : memory command
//   mem_ready, mem_read_data                       : memory response
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
   parameter int XLEN = 32
) ();
   logic            req0;
   logic            req1;
   logic            we0;
   logic            we1;
   logic [XLEN-1:0] addr0;
   logic [XLEN-1:0] addr1;
   logic [XLEN-1:0] wdata0;
   logic [XLEN-1:0] wdata1;
   logic            done0;
   logic            done1;
   logic            err0;
   logic            err1;
   logic [XLEN-1:0] rdata0;
   logic [XLEN-1:0] rdata1;
   logic            busy;
   logic            grant_id;
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_write_data;
   logic            mem_read;
   logic            mem_write;
   logic            mem_ready;
   logic [XLEN-1:0] mem_read_data;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      input  mem_ready, mem_read_data,
      output done0, done1, err0, err1, rdata0, rdata1, busy, grant_id,
      output mem_addr, mem_write_data, mem_read, mem_write
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      output mem_ready, mem_read_data,
      input  done0, done1, err0, err1, rdata0, rdata1, busy, grant_id,
      input  mem_addr, mem_write_data, mem_read, mem_write
   );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Round-robin arbiter and access sequencer placing two requesters (port 0:
// instruction fetch, port 1: load/store) in front of one single-port memory.
// Each access runs IDLE -> ISSUE -> WAIT -> DONE; WAIT is bounded by TIMEOUT
// cycles so a memory that never answers still produces a completion (err=1).
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mem_arbiter_if.slave (requests, completions, memory bus)
// Every output is a flop; next values are derived from the next state so no
// input reaches an output combinationally.
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 15
) (
   input logic          clk,
   input logic          rst_n,
   mem_arbiter_if.slave bus
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t          state_q,  state_d;
   logic            prio_q,   prio_d;
   logic            we_q,     we_d;
   logic            grant_q,  grant_d;
   logic [CW-1:0]   cnt_q,    cnt_d;
   logic [XLEN-1:0] addr_q,   addr_d;
   logic [XLEN-1:0] wdata_q,  wdata_d;
   logic [XLEN-1:0] rdata0_q, rdata0_d;
   logic [XLEN-1:0] rdata1_q, rdata1_d;
   logic            done0_q,  done0_d;
   logic            done1_q,  done1_d;
   logic            err0_q,   err0_d;
   logic            err1_q,   err1_d;
   logic            mrd_q,    mrd_d;
   logic            mwr_q,    mwr_d;
   logic            busy_q,   busy_d;

   logic            win_s;
   logic            tout_s;
   logic [CW-1:0]   cnt_inc_s;

   // Next-state, arbitration, timeout and next-output decode
   always_comb begin
      state_d  = state_q;
      prio_d   = prio_q;
      we_d     = we_q;
      grant_d  = grant_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      win_s    = 1'b0;
      tout_s   = 1'b0;
      // saturating increment: the counter may never wrap back to zero
      cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);

      case (state_q)
         ST_IDLE: begin
            if (bus.req0 || bus.req1) begin
               // a lone requester wins outright; on contention prio decides
               if (bus.req0 && bus.req1) begin
                  win_s = prio_q;
               end else begin
                  win_s = bus.req1;
               end
               grant_d = win_s;
               prio_d  = ~win_s;
               if (win_s) begin
                  we_d    = bus.we1;
                  addr_d  = bus.addr1;
                  wdata_d = bus.wdata1;
               end else begin
                  we_d    = bus.we0;
                  addr_d  = bus.addr0;
                  wdata_d = bus.wdata0;
               end
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = CNT_ZERO;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (bus.mem_ready) begin
               if (!we_q) begin
                  if (grant_q) begin
                     rdata1_d = bus.mem_read_data;
                  end else begin
                     rdata0_d = bus.mem_read_data;
                  end
               end else begin
                  rdata0_d = rdata0_q;
               end
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_inc_s;
               // TIMEOUT silent WAIT cycles end the access with an error
               if (cnt_inc_s == CNT_MAX) begin
                  tout_s  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // outputs for the coming cycle follow directly from the coming state
      busy_d  = (state_d != ST_IDLE);
      mrd_d   = (state_d == ST_ISSUE) && !we_d;
      mwr_d   = (state_d == ST_ISSUE) &&  we_d;
      done0_d = (state_d == ST_DONE) && !grant_d;
      done1_d = (state_d == ST_DONE) &&  grant_d;
      err0_d  = done0_d && tout_s;
      err1_d  = done1_d && tout_s;
   end

   // State and output registers; reset drops any in-flight access silently
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         prio_q   <= 1'b0;
         we_q     <= 1'b0;
         grant_q  <= 1'b0;
         cnt_q    <= CNT_ZERO;
         addr_q   <= {XLEN{1'b0}};
         wdata_q  <= {XLEN{1'b0}};
         rdata0_q <= {XLEN{1'b0}};
         rdata1_q <= {XLEN{1'b0}};
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         err0_q   <= 1'b0;
         err1_q   <= 1'b0;
         mrd_q    <= 1'b0;
         mwr_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         prio_q   <= prio_d;
         we_q     <= we_d;
         grant_q  <= grant_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
         err0_q   <= err0_d;
         err1_q   <= err1_d;
         mrd_q    <= mrd_d;
         mwr_q    <= mwr_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.done0          = done0_q;
   assign bus.done1          = done1_q;
   assign bus.err0           = err0_q;
   assign bus.err1           = err1_q;
   assign bus.rdata0         = rdata0_q;
   assign bus.rdata1         = rdata1_q;
   assign bus.busy           = busy_q;
   assign bus.grant_id       = grant_q;
   assign bus.mem_addr       = addr_q;
   assign bus.mem_write_data = wdata_q;
   assign bus.mem_read       = mrd_q;
   assign bus.mem_write      = mwr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter with a small behavioural memory (normal,
// never-ready and late-ready modes) and a transaction-level model of the
// arbiter that predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
   localparam int XLEN = 32;
   localparam int TO   = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if #(.XLEN(XLEN)) bus ();

   mem_arbiter #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural memory ----------------
   logic [31:0] mem [0:63];
   int   mem_mode = 0;     // 0 normal, 1 never ready, 2 ready 3 cycles late
   logic stray    = 1'b0;  // forces one mem_ready while nothing is pending
   logic pend;
   int   dly;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.mem_ready     <= 1'b0;
         bus.mem_read_data <= 32'h0;
         pend              <= 1'b0;
         dly               <= 0;
      end else if (bus.mem_read || bus.mem_write) begin
         bus.mem_read_data <= mem[bus.mem_addr[5:0]];
         if (bus.mem_write) mem[bus.mem_addr[5:0]] <= bus.mem_write_data;
         bus.mem_ready <= (mem_mode == 0);
         pend          <= (mem_mode == 2);
         dly           <= 2;
      end else if (pend) begin
         if (dly == 0) begin
            bus.mem_ready <= 1'b1;
            pend          <= 1'b0;
         end else begin
            dly           <= dly - 1;
            bus.mem_ready <= 1'b0;
         end
      end else begin
         bus.mem_ready <= stray;
      end
   end

   // ---------------- transaction-level model ----------------
   logic [31:0] e_rdata0, e_rdata1, e_addr, e_wdata;
   logic e_done0, e_done1, e_err0, e_err1, e_busy, e_grant, e_rd, e_wr;
   bit   m_active, m_in_done, m_port, m_we, m_prio;
   int   m_age, m_waits;

   task automatic model_reset();
      e_rdata0 = 32'h0; e_rdata1 = 32'h0; e_addr = 32'h0; e_wdata = 32'h0;
      e_done0 = 1'b0; e_done1 = 1'b0; e_err0 = 1'b0; e_err1 = 1'b0;
      e_busy = 1'b0; e_grant = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
      m_active = 1'b0; m_in_done = 1'b0; m_port = 1'b0; m_we = 1'b0;
      m_prio = 1'b0; m_age = 0; m_waits = 0;
   endtask

   // predicts outputs for the cycle after the next rising edge
   task automatic model_step();
      bit fin;
      bit tmo;
      fin = 1'b0;
      tmo = 1'b0;
      e_done0 = 1'b0; e_done1 = 1'b0; e_err0 = 1'b0; e_err1 = 1'b0;
      e_rd = 1'b0; e_wr = 1'b0;
      if (m_in_done) begin
         m_in_done = 1'b0;
         m_active  = 1'b0;
         e_busy    = 1'b0;
      end else if (!m_active) begin
         if (bus.req0 || bus.req1) begin
            m_port  = (bus.req0 && bus.req1) ? m_prio : bus.req1;
            m_prio  = !m_port;
            m_we    = m_port ? bus.we1 : bus.we0;
            e_addr  = m_port ? bus.addr1 : bus.addr0;
            e_wdata = m_port ? bus.wdata1 : bus.wdata0;
            e_grant = m_port;
            e_busy  = 1'b1;
            e_rd    = !m_we;
            e_wr    = m_we;
            m_active = 1'b1;
            m_age    = 1;
         end else begin
            e_busy = 1'b0;
         end
      end else if (m_age == 1) begin
         m_age   = 2;
         m_waits = 0;
      end else begin
         if (bus.mem_ready) begin
            fin = 1'b1;
            if (!m_we) begin
               if (m_port) e_rdata1 = bus.mem_read_data;
               else        e_rdata0 = bus.mem_read_data;
            end
         end else begin
            m_waits++;
            if (m_waits >= TO) begin
               fin = 1'b1;
               tmo = 1'b1;
            end
         end
         if (fin) begin
            m_in_done = 1'b1;
            if (m_port) begin e_done1 = 1'b1; e_err1 = tmo; end
            else        begin e_done0 = 1'b1; e_err0 = tmo; end
         end
      end
   endtask

   initial model_reset();

   // single compare process: every output, every cycle
   always @(negedge clk) begin
      if (!rst_n) model_reset();
      chk("done0",  bus.done0,  e_done0);
      chk("done1",  bus.done1,  e_done1);
      chk("err0",   bus.err0,   e_err0);
      chk("err1",   bus.err1,   e_err1);
      chk("rdata0", bus.rdata0, e_rdata0);
      chk("rdata1", bus.rdata1, e_rdata1);
      chk("busy",   bus.busy,   e_busy);
      chk("mem_read",  bus.mem_read,  e_rd);
      chk("mem_write", bus.mem_write, e_wr);
      chk("mem_addr",  bus.mem_addr,  e_addr);
      chk("mem_wdata", bus.mem_write_data, e_wdata);
      chk("rd_wr_excl", bus.mem_read & bus.mem_write, 32'h0);
      if (e_busy) chk("grant_id", bus.grant_id, e_grant);
      if (rst_n) model_step();
   end

   int rd_cnt = 0;
   int dn_cnt = 0;
   always @(negedge clk) begin
      if (bus.mem_read) rd_cnt++;
      if (bus.done0 || bus.done1) dn_cnt++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic start_req(input bit p, input bit w, input logic [31:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      if (p) begin bus.req1 = 1'b1; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d; end
      else   begin bus.req0 = 1'b1; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d; end
   endtask

   task automatic wait_done(input bit p, output int lat);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if ((p ? bus.done1 : bus.done0) == 1'b1) begin
            lat = i;
            break;
         end
      end
      if (lat < 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL done_wait: no done on port %0d within 40 cycles", p);
      end
   endtask

   task automatic drop_req(input bit p);
      @(posedge clk); #1;
      if (p) bus.req1 = 1'b0;
      else   bus.req0 = 1'b0;
   endtask

   initial begin
      int lat;
      int rd0;
      int dn0;
      int seq_port [$];
      int seq_cyc  [$];

      bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
      bus.addr0 = 32'h0; bus.addr1 = 32'h0; bus.wdata0 = 32'h0; bus.wdata1 = 32'h0;
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[5]  = 32'hDEAD_BEEF;
      mem[12] = 32'hCAFE_F00D;
      mem[20] = 32'hA0A0_0020;
      mem[21] = 32'hB1B1_0021;

      // reset state
      @(posedge clk); #1;
      chk("rst_busy",  bus.busy,     32'h0);
      chk("rst_rdata", bus.rdata0,   32'h0);
      chk("rst_maddr", bus.mem_addr, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // single read on port 0
      rd0 = rd_cnt;
      start_req(1'b0, 1'b0, 32'd5, 32'h0);
      wait_done(1'b0, lat);
      chk("read_latency", lat, 32'd3);
      chk("read_data", bus.rdata0, 32'hDEAD_BEEF);
      chk("read_err", bus.err0, 32'h0);
      chk("read_done1_quiet", bus.done1, 32'h0);
      drop_req(1'b0);
      chk("read_issue_cycles", rd_cnt - rd0, 32'd1);

      // write then read on port 1
      start_req(1'b1, 1'b1, 32'd9, 32'h1234_5678);
      wait_done(1'b1, lat);
      chk("write_keeps_rdata1", bus.rdata1, 32'h0);
      drop_req(1'b1);
      start_req(1'b1, 1'b0, 32'd9, 32'h0);
      wait_done(1'b1, lat);
      chk("wr_rd_latency", lat, 32'd3);
      chk("wr_rd_data", bus.rdata1, 32'h1234_5678);
      drop_req(1'b1);

      // timeout: memory never answers
      mem_mode = 1;
      start_req(1'b0, 1'b0, 32'd7, 32'h0);
      wait_done(1'b0, lat);
      chk("tmo_latency", lat, 32'd6);
      chk("tmo_err", bus.err0, 32'h1);
      chk("tmo_rdata_kept", bus.rdata0, 32'hDEAD_BEEF);
      drop_req(1'b0);
      chk("tmo_back_idle", bus.busy, 32'h0);
      mem_mode = 0;

      // late ready on the last WAIT cycle before timeout
      mem_mode = 2;
      start_req(1'b1, 1'b0, 32'd12, 32'h0);
      wait_done(1'b1, lat);
      chk("late_latency", lat, 32'd6);
      chk("late_err", bus.err1, 32'h0);
      chk("late_data", bus.rdata1, 32'hCAFE_F00D);
      drop_req(1'b1);
      mem_mode = 0;

      // stray ready in IDLE
      dn0 = dn_cnt;
      @(posedge clk); #1; stray = 1'b1;
      @(posedge clk); #1; stray = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("stray_no_done", dn_cnt - dn0, 32'h0);

      // reset in the middle of WAIT
      mem_mode = 1;
      start_req(1'b0, 1'b0, 32'd5, 32'h0);
      @(posedge clk);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy",  bus.busy,     32'h0);
      chk("mid_rst_mrd",   bus.mem_read, 32'h0);
      chk("mid_rst_maddr", bus.mem_addr, 32'h0);
      chk("mid_rst_rdata", bus.rdata0,   32'h0);
      bus.req0 = 1'b0;
      mem_mode = 0;
      dn0 = dn_cnt;
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'd21;
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_grant_busy", bus.busy, 32'h1);
      chk("post_rst_grant_id", bus.grant_id, 32'h1);
      chk("post_rst_no_done", dn_cnt - dn0, 32'h0);
      @(posedge clk);
      @(posedge clk); #1;
      chk("post_rst_done1", bus.done1, 32'h1);
      chk("post_rst_data", bus.rdata1, 32'hB1B1_0021);
      drop_req(1'b1);

      // contention from reset: both held, grants must alternate
      @(posedge clk); #1;
      rst_n = 1'b0;
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'd20;
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'd21;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         @(posedge clk); #1;
         if (bus.done0) begin seq_port.push_back(0); seq_cyc.push_back(c); end
         if (bus.done1) begin seq_port.push_back(1); seq_cyc.push_back(c); end
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      chk("cont_count", seq_port.size(), 32'd4);
      for (int k = 0; k < seq_port.size() && k < 4; k++) begin
         chk("cont_order", seq_port[k], k % 2);
         chk("cont_cycle", seq_cyc[k], 3 + 4 * k);
      end
      chk("cont_rdata0", bus.rdata0, 32'hA0A0_0020);
      chk("cont_rdata1", bus.rdata1, 32'hB1B1_0021);
      repeat (3) @(posedge clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
